// File: rtl/axil_write_arbiter_if.sv
// Bundle of the requester-side and AXI4-Lite write-channel signals of the
// two-requester write arbiter. The master modport is the arbiter's view and
// the slave modport is the environment's view (requesters plus AXI slave).
interface axil_write_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Requester side
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2*ADDR_W-1:0]   req_addr;
  logic [2*DATA_W-1:0]   req_data;
  logic [2*STRB_W-1:0]   req_strb;
  logic [1:0]            done;
  logic [1:0]            done_resp;

  // AXI4-Lite write channels
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [STRB_W-1:0]     WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;

  // Status
  logic                  busy;
  logic                  grant_id;

  modport master (
    input  req_valid, req_addr, req_data, req_strb,
    input  AWREADY, WREADY, BVALID, BRESP,
    output req_ready, done, done_resp,
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
    output busy, grant_id
  );

  modport slave (
    output req_valid, req_addr, req_data, req_strb,
    output AWREADY, WREADY, BVALID, BRESP,
    input  req_ready, done, done_resp,
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
    input  busy, grant_id
  );
endinterface

// File: rtl/axil_write_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the AXI4-Lite write
// path. One request is accepted at a time in IDLE, its payload is latched,
// AW and W are driven with independent handshakes, the B response is
// collected and returned to the granted requester as a one-cycle done pulse.
module axil_write_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axil_write_arbiter_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                grant_q, grant_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          done_resp_q, done_resp_d;

  logic                accept_s;
  logic                grant_s;
  logic [1:0]          req_ready_s;
  logic                aw_hs_s;
  logic                w_hs_s;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    accept_s = |bus.req_valid;
    grant_s  = 1'b0;
    if (bus.req_valid == 2'b11) begin
      grant_s = rr_q;
    end else if (bus.req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Accept strobe back to the winner; only offered while idle and out of reset.
  always_comb begin
    req_ready_s = 2'b00;
    if ((state_q == IDLE) && accept_s && ARESETn) begin
      req_ready_s = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign aw_hs_s = awvalid_q & bus.AWREADY;
  assign w_hs_s  = wvalid_q  & bus.WREADY;

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    done_d      = 2'b00;
    done_resp_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          grant_d   = grant_s;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = XFER;
          if (grant_s) begin
            awaddr_d = bus.req_addr[2*ADDR_W-1:ADDR_W];
            wdata_d  = bus.req_data[2*DATA_W-1:DATA_W];
            wstrb_d  = bus.req_strb[2*STRB_W-1:STRB_W];
          end else begin
            awaddr_d = bus.req_addr[ADDR_W-1:0];
            wdata_d  = bus.req_data[DATA_W-1:0];
            wstrb_d  = bus.req_strb[STRB_W-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // Each channel drops on its own handshake and is remembered as done.
        awvalid_d = awvalid_q & ~bus.AWREADY;
        wvalid_d  = wvalid_q  & ~bus.WREADY;
        aw_done_d = aw_done_q | aw_hs_s;
        w_done_d  = w_done_q  | w_hs_s;
        if ((aw_done_q | aw_hs_s) && (w_done_q | w_hs_s)) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end else begin
          state_d = XFER;
        end
      end
      RESP: begin
        if (bready_q && bus.BVALID) begin
          bready_d    = 1'b0;
          done_d      = grant_q ? 2'b10 : 2'b01;
          done_resp_d = bus.BRESP;
          rr_d        = ~grant_q;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      grant_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      done_q      <= 2'b00;
      done_resp_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.done      = done_q;
  assign bus.done_resp = done_resp_q;
  assign bus.AWVALID   = awvalid_q;
  assign bus.AWADDR    = awaddr_q;
  assign bus.WVALID    = wvalid_q;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.BREADY    = bready_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_axil_write_arbiter.sv
// Self-checking bench for axil_write_arbiter. Stimulus pushes the expected
// AW/W/B events into queues; a monitor pops and compares whenever the DUT
// completes an AW or W handshake or pulses done.
module tb_axil_write_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        id;
    logic [1:0]  resp;
  } exp_t;

  logic clk;
  logic aresetn;
  int   chk_cnt;
  int   pass_cnt;
  exp_t aw_q[$];
  exp_t w_q[$];
  exp_t b_q[$];

  axil_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK    (clk),
    .ARESETn (aresetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expect_xfer(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic id, input logic [1:0] r);
    exp_t e;
    e.addr = a; e.data = d; e.strb = s; e.id = id; e.resp = r;
    aw_q.push_back(e);
    w_q.push_back(e);
    b_q.push_back(e);
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (n == 0) begin
      bus.req_addr[31:0] = a; bus.req_data[31:0] = d; bus.req_strb[3:0] = s;
    end else begin
      bus.req_addr[63:32] = a; bus.req_data[63:32] = d; bus.req_strb[7:4] = s;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Scoreboard monitor: compares every presented handshake / completion.
  always @(negedge clk) begin
    exp_t e;
    if (aresetn) begin
      if (bus.AWVALID && bus.AWREADY) begin
        if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          e = aw_q.pop_front();
          check("awaddr", 64'(bus.AWADDR), 64'(e.addr));
        end
      end
      if (bus.WVALID && bus.WREADY) begin
        if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          e = w_q.pop_front();
          check("wdata", 64'(bus.WDATA), 64'(e.data));
          check("wstrb", 64'(bus.WSTRB), 64'(e.strb));
        end
      end
      if (|bus.done) begin
        if (b_q.size() == 0) check("done_unexpected", 64'(bus.done), 64'd0);
        else begin
          e = b_q.pop_front();
          check("done_bits", 64'(bus.done), e.id ? 64'd2 : 64'd1);
          check("done_resp", 64'(bus.done_resp), 64'(e.resp));
          check("grant_id", 64'(bus.grant_id), 64'(e.id));
        end
      end
    end
  end

  initial begin
    int n_done;
    chk_cnt = 0;
    pass_cnt = 0;
    aresetn = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_strb = '0;
    bus.AWREADY = 1'b1;
    bus.WREADY = 1'b1;
    bus.BVALID = 1'b1;
    bus.BRESP = 2'b00;

    // Contention from reset: both requesters valid continuously
    set_req(0, 32'h40, 32'hA5A5A5A5, 4'h3);
    set_req(1, 32'h20, 32'h12345678, 4'hC);
    bus.req_valid = 2'b11;
    run_cycles(2);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_valids", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.busy, bus.grant_id}), 64'd0);
    check("rst_done", 64'({bus.done, bus.done_resp}), 64'd0);
    check("rst_payload", {bus.AWADDR, bus.WDATA}, 64'd0);
    check("rst_wstrb", 64'(bus.WSTRB), 64'd0);
    expect_xfer(32'h40, 32'hA5A5A5A5, 4'h3, 1'b0, 2'b00);
    expect_xfer(32'h20, 32'h12345678, 4'hC, 1'b1, 2'b00);
    expect_xfer(32'h40, 32'hA5A5A5A5, 4'h3, 1'b0, 2'b00);
    expect_xfer(32'h20, 32'h12345678, 4'hC, 1'b1, 2'b00);
    aresetn = 1'b1;
    n_done = 0;
    for (int i = 0; i < 60 && n_done < 4; i++) begin
      @(negedge clk);
      if (|bus.done) n_done++;
    end
    bus.req_valid = 2'b00;
    check("contention_done_count", 64'(n_done), 64'd4);

    // Single write from requester 0, all readys high
    next_cycle();
    set_req(0, 32'h10, 32'hDEADBEEF, 4'hF);
    expect_xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 2'b00);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("single_req_ready", 64'(bus.req_ready), 64'd1);
    next_cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("single_c1_valids", 64'({bus.AWVALID, bus.WVALID}), 64'd3);
    next_cycle();
    @(negedge clk);
    check("single_c2_bready", 64'(bus.BREADY), 64'd1);
    next_cycle();
    @(negedge clk);
    check("single_c3_done", 64'(bus.done), 64'd1);
    check("single_c3_busy", 64'(bus.busy), 64'd0);

    // Skewed handshake: W completes at cycle 1, AW at cycle 4
    next_cycle();
    bus.AWREADY = 1'b0;
    bus.BRESP = 2'b01;
    set_req(0, 32'h44, 32'h0BADF00D, 4'h5);
    expect_xfer(32'h44, 32'h0BADF00D, 4'h5, 1'b0, 2'b01);
    bus.req_valid = 2'b01;
    next_cycle();
    bus.req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    check("skew_c2_valids", 64'({bus.AWVALID, bus.WVALID}), 64'd2);
    next_cycle();
    @(negedge clk);
    check("skew_c3_awaddr", 64'(bus.AWADDR), 64'h44);
    check("skew_c3_bready", 64'(bus.BREADY), 64'd0);
    next_cycle();
    bus.AWREADY = 1'b1;
    @(negedge clk);
    check("skew_c4_bready", 64'(bus.BREADY), 64'd0);
    next_cycle();
    @(negedge clk);
    check("skew_c5_bready", 64'({bus.BREADY, bus.AWVALID}), 64'd2);
    next_cycle();
    @(negedge clk);
    check("skew_c6_done", 64'(bus.done), 64'd1);

    // Error response with BVALID delayed six cycles, zero strobes
    next_cycle();
    bus.BVALID = 1'b0;
    bus.BRESP = 2'b10;
    set_req(0, 32'h80, 32'hCAFEF00D, 4'h0);
    expect_xfer(32'h80, 32'hCAFEF00D, 4'h0, 1'b0, 2'b10);
    bus.req_valid = 2'b01;
    next_cycle();
    bus.req_valid = 2'b00;
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("err_bready_held", 64'({bus.BREADY, bus.done}), 64'h4);
      next_cycle();
    end
    bus.BVALID = 1'b1;
    next_cycle();
    @(negedge clk);
    check("err_done", 64'({bus.done, bus.done_resp}), 64'h6);
    next_cycle();
    @(negedge clk);
    check("err_single_pulse", 64'({bus.done, bus.BREADY}), 64'd0);

    // Reset in the middle of a requester-1 transfer
    next_cycle();
    bus.AWREADY = 1'b0;
    bus.WREADY = 1'b0;
    bus.BVALID = 1'b0;
    bus.BRESP = 2'b00;
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("mid_req_ready", 64'(bus.req_ready), 64'd2);
    next_cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("mid_awvalid", 64'({bus.AWVALID, bus.busy, bus.grant_id}), 64'd7);
    next_cycle();
    aresetn = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.busy, bus.grant_id, bus.done}), 64'd0);
    check("mid_rst_awaddr", 64'(bus.AWADDR), 64'd0);
    set_req(0, 32'h60, 32'h600DCAFE, 4'hF);
    bus.AWREADY = 1'b1;
    bus.WREADY = 1'b1;
    bus.BVALID = 1'b1;
    bus.req_valid = 2'b11;
    expect_xfer(32'h60, 32'h600DCAFE, 4'hF, 1'b0, 2'b00);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("post_rst_grant", 64'(bus.req_ready), 64'd1);
    next_cycle();
    bus.req_valid = 2'b00;
    run_cycles(4);

    // Stray response while idle
    bus.BVALID = 1'b1;
    bus.BRESP = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_idle", 64'({bus.BREADY, bus.busy, bus.done}), 64'd0);
      next_cycle();
    end
    bus.BVALID = 1'b0;
    run_cycles(2);

    check("aw_q_empty", 64'(aw_q.size()), 64'd0);
    check("w_q_empty", 64'(w_q.size()), 64'd0);
    check("b_q_empty", 64'(b_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
